// File: rtl/la_sample_ctrl_if.sv
// RAM write / display-control bundle between the sample controller and la_wave_display.
// wr_en is a one-cycle strobe qualifying wr_data/wr_addr; there is no ready, the RAM takes every strobe.
interface la_sample_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] start_addr;
  logic          trigger_en;

  modport master (
    output wr_data,
    output wr_en,
    output wr_addr,
    output start_addr,
    output trigger_en
  );

  modport slave (
    input wr_data,
    input wr_en,
    input wr_addr,
    input start_addr,
    input trigger_en
  );
endinterface

// File: rtl/la_sample_ctrl.sv
// Logic-analyzer capture controller: divided sample tick, circular RAM writes,
// pre-trigger hold, mask/level/edge trigger and post-trigger fill.
module la_sample_ctrl #(
  parameter int AW    = 10,
  parameter int DW    = 8,
  parameter int DIV_W = 16
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    din,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [AW-1:0]    pre_num,
  input  logic [DW-1:0]    trig_mask,
  input  logic [DW-1:0]    trig_edge,
  input  logic [DW-1:0]    trig_val,
  la_sample_ctrl_if.master ram,
  output logic             done,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] ONE_AW = AW'(1);

  state_t           state, state_n;
  logic [DIV_W-1:0] div_q, cnt;
  logic [AW-1:0]    pre_q, pre_cnt, post_left, ptr;
  logic [DW-1:0]    mask_q, edge_q, val_q, prev;
  logic             first_q;

  logic [DW-1:0]    wr_data_q;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q, start_addr_q;
  logic             trigger_en_q;

  logic             arm, capturing, tick, hit;
  logic [DW-1:0]    prev_eff, ch_ok;

  assign arm       = (state == S_IDLE) && start && !stop;
  assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  // stop suppresses the write of a tick landing in the same cycle
  assign tick      = capturing && (cnt == div_q) && !stop;

  // The first tick of a capture compares against itself so no edge is invented
  // from whatever prev held before arming.
  always_comb begin
    prev_eff = first_q ? din : prev;
    ch_ok    = '0;
    for (int i = 0; i < DW; i++) begin
      if (!mask_q[i])
        ch_ok[i] = 1'b1;
      else if (edge_q[i])
        ch_ok[i] = val_q[i] ? (~prev_eff[i] & din[i]) : (prev_eff[i] & ~din[i]);
      else
        ch_ok[i] = (din[i] == val_q[i]);
    end
    hit = &ch_ok;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (arm) state_n = (pre_num == '0) ? S_WAIT : S_PRE;
      S_PRE:  if (tick && (pre_cnt + ONE_AW == pre_q)) state_n = S_WAIT;
      S_WAIT: if (tick && hit) state_n = (pre_q == '1) ? S_DONE : S_POST;
      S_POST: if (tick && (post_left == ONE_AW)) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (stop && (state != S_IDLE)) state_n = S_IDLE;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      div_q        <= '0;
      pre_q        <= '0;
      mask_q       <= '0;
      edge_q       <= '0;
      val_q        <= '0;
      pre_cnt      <= '0;
      post_left    <= '0;
      ptr          <= '0;
      prev         <= '0;
      first_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      start_addr_q <= '0;
      trigger_en_q <= 1'b0;
    end else begin
      if (state == S_IDLE || cnt == div_q)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (arm) begin
        div_q   <= div;
        pre_q   <= pre_num;
        mask_q  <= trig_mask;
        edge_q  <= trig_edge;
        val_q   <= trig_val;
        ptr     <= '0;
        pre_cnt <= '0;
        first_q <= 1'b1;
      end

      wr_en_q <= tick;
      if (tick) begin
        wr_data_q <= din;
        wr_addr_q <= ptr;
        ptr       <= ptr + 1'b1;
        prev      <= din;
        first_q   <= 1'b0;
        if (state == S_PRE)
          pre_cnt <= pre_cnt + 1'b1;
        if (state == S_WAIT && hit) begin
          start_addr_q <= ptr - pre_q;
          // trigger sample already counts as the first of 2**AW - pre_q post writes
          post_left    <= ~pre_q;
        end
        if (state == S_POST)
          post_left <= post_left - 1'b1;
      end

      if ((stop && state != S_IDLE) || state == S_DONE)
        trigger_en_q <= 1'b0;
      else if (arm)
        trigger_en_q <= 1'b1;
    end
  end

  assign ram.wr_data    = wr_data_q;
  assign ram.wr_en      = wr_en_q;
  assign ram.wr_addr    = wr_addr_q;
  assign ram.start_addr = start_addr_q;
  assign ram.trigger_en = trigger_en_q;
  assign done           = (state == S_DONE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_la_sample_ctrl.sv
// Bench for la_sample_ctrl: table of whole captures plus hand sequences for
// wrap without trigger, reset mid-capture and stop during POST.
module tb_la_sample_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DIV_W = 16;

  logic             sys_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    din = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [AW-1:0]    pre_num = '0;
  logic [DW-1:0]    trig_mask = '0;
  logic [DW-1:0]    trig_edge = '0;
  logic [DW-1:0]    trig_val = '0;
  logic             done;
  logic [2:0]       state_dbg;

  la_sample_ctrl_if #(.AW(AW), .DW(DW)) ram_if ();

  la_sample_ctrl #(.AW(AW), .DW(DW), .DIV_W(DIV_W)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .din       (din),
    .start     (start),
    .stop      (stop),
    .div       (div),
    .pre_num   (pre_num),
    .trig_mask (trig_mask),
    .trig_edge (trig_edge),
    .trig_val  (trig_val),
    .ram       (ram_if),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 sys_clk = ~sys_clk;

  // din is a before t1, b from tick t1, c from tick t2; trig is the tick index that fires
  typedef struct {
    logic [DIV_W-1:0] div;
    logic [AW-1:0]    pre;
    logic [DW-1:0]    mask, edg, val, a, b, c;
    int               t1, t2, trig;
    int               e_start, e_writes;
    logic [DW-1:0]    e_dtrig, e_dprev;
  } vec_t;

  vec_t vecs [6];
  logic [DW-1:0] ram_m [1024];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge sys_clk); #1 start = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
  endtask

  task automatic run_capture(input vec_t v, input string tag);
    int dv, budget, wr_cnt, last_c, first_lat, addr_err, gap_err, ten_err;
    bit got_done;
    dv = int'(v.div) + 1;
    budget = v.e_writes * dv + 50;
    wr_cnt = 0; last_c = 0; first_lat = -1; addr_err = 0; gap_err = 0; ten_err = 0;
    got_done = 1'b0;
    div = v.div; pre_num = v.pre; trig_mask = v.mask; trig_edge = v.edg; trig_val = v.val;
    din = v.a;
    pulse_start();
    // scrambled configuration must be ignored until the next start
    div = DIV_W'($urandom_range(0, 7));
    pre_num = AW'($urandom_range(0, 1023));
    trig_mask = DW'($urandom_range(0, 255));
    trig_edge = DW'($urandom_range(0, 255));
    trig_val = DW'($urandom_range(0, 255));
    for (int c = 1; c <= budget; c++) begin
      @(posedge sys_clk); #1;
      if (c == v.t1 * dv) din = v.b;
      if (c == v.t2 * dv) din = v.c;
      if (ram_if.wr_en) begin
        if (int'(ram_if.wr_addr) != wr_cnt % 1024) addr_err++;
        if (wr_cnt == 0) first_lat = c;
        else if (c - last_c != dv) gap_err++;
        last_c = c;
        ram_m[ram_if.wr_addr] = ram_if.wr_data;
        wr_cnt++;
      end
      if (ram_if.trigger_en !== 1'b1) ten_err++;
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
    end
    check({tag, " done"}, 32'(got_done), 32'd1);
    check({tag, " start_addr"}, 32'(ram_if.start_addr), 32'(v.e_start));
    check({tag, " writes"}, wr_cnt, v.e_writes);
    check({tag, " first_latency"}, first_lat, dv);
    check({tag, " addr_seq_err"}, addr_err, 0);
    check({tag, " gap_err"}, gap_err, 0);
    check({tag, " trigger_en_low"}, ten_err, 0);
    check({tag, " data_at_trig"}, 32'(ram_m[v.trig % 1024]), 32'(v.e_dtrig));
    check({tag, " data_before_trig"}, 32'(ram_m[(v.trig + 1023) % 1024]), 32'(v.e_dprev));
    @(posedge sys_clk); #1;
    check({tag, " idle_after_done"}, {29'd0, done, ram_if.trigger_en, ram_if.wr_en}, 32'd0);
  endtask

  initial begin
    int wr_cnt, addr_err, ten_err, done_cnt, act_cnt;
    bit wrap;
    logic [AW-1:0] last_addr;

    //         div    pre     mask   edg    val    a      b      c      t1    t2    trig  start writes dtrig  dprev
    vecs[0] = '{16'd0, 10'd0,    8'h00, 8'h00, 8'h00, 8'h3C, 8'h5A, 8'h5A, 5,    6,    0,    0,   1024,  8'h3C, 8'h5A};
    vecs[1] = '{16'd0, 10'd100,  8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 299,  300,  299,  199, 1223,  8'h01, 8'h00};
    vecs[2] = '{16'd3, 10'd4,    8'h81, 8'h00, 8'h81, 8'h00, 8'hA5, 8'hA5, 10,   11,   10,   6,   1030,  8'hA5, 8'h00};
    vecs[3] = '{16'd1, 10'd1000, 8'h02, 8'h02, 8'h00, 8'h02, 8'h00, 8'h00, 1034, 1035, 1034, 34,  1058,  8'h00, 8'h02};
    vecs[4] = '{16'd2, 10'd3,    8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 3,    4,    3,    0,   1024,  8'h00, 8'h01};
    vecs[5] = '{16'd0, 10'd0,    8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 3,    7,    7,    7,   1031,  8'h01, 8'h01};

    // reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst wr_en", 32'(ram_if.wr_en), 32'd0);
    check("rst wr_addr", 32'(ram_if.wr_addr), 32'd0);
    check("rst wr_data", 32'(ram_if.wr_data), 32'd0);
    check("rst start_addr", 32'(ram_if.start_addr), 32'd0);
    check("rst trigger_en", 32'(ram_if.trigger_en), 32'd0);
    check("rst done_state", {28'd0, done, state_dbg}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_capture(vecs[i], $sformatf("vec%0d", i));

    // no trigger: pointer wraps freely, a stray start is ignored, stop aborts
    div = '0; pre_num = '0; trig_mask = 8'h01; trig_edge = 8'h00; trig_val = 8'h01; din = 8'h00;
    pulse_start();
    wr_cnt = 0; addr_err = 0; ten_err = 0; done_cnt = 0; wrap = 1'b0; last_addr = '0;
    for (int c = 1; c <= 2100; c++) begin
      @(posedge sys_clk); #1;
      if (c == 500) begin start = 1'b1; pre_num = 10'd5; end
      if (c == 501) start = 1'b0;
      if (ram_if.wr_en) begin
        if (int'(ram_if.wr_addr) != wr_cnt % 1024) addr_err++;
        if (wr_cnt > 0 && last_addr == 10'd1023 && ram_if.wr_addr == 10'd0) wrap = 1'b1;
        last_addr = ram_if.wr_addr;
        wr_cnt++;
      end
      if (ram_if.trigger_en !== 1'b1) ten_err++;
      if (done === 1'b1) done_cnt++;
    end
    check("notrig writes", wr_cnt, 2100);
    check("notrig addr_seq_err", addr_err, 0);
    check("notrig wrapped", 32'(wrap), 32'd1);
    check("notrig done_count", done_cnt, 0);
    check("notrig trigger_en_low", ten_err, 0);
    stop = 1'b1;
    @(posedge sys_clk); #1 stop = 1'b0;
    check("notrig stop wr_en", 32'(ram_if.wr_en), 32'd0);
    check("notrig stop trigger_en", 32'(ram_if.trigger_en), 32'd0);
    check("notrig stop done_state", {28'd0, done, state_dbg}, 32'd0);
    check("notrig start_addr_held", 32'(ram_if.start_addr), 32'd7);

    // reset in the middle of a capture
    div = '0; pre_num = '0; trig_mask = 8'h01; trig_edge = 8'h00; trig_val = 8'h01; din = 8'hFE;
    pulse_start();
    repeat (20) @(posedge sys_clk);
    #1;
    check("midrst capturing", {30'd0, ram_if.wr_en, ram_if.trigger_en}, 32'd3);
    rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check("midrst wr_en", 32'(ram_if.wr_en), 32'd0);
    check("midrst wr_data", 32'(ram_if.wr_data), 32'd0);
    check("midrst wr_addr", 32'(ram_if.wr_addr), 32'd0);
    check("midrst start_addr", 32'(ram_if.start_addr), 32'd0);
    check("midrst trigger_en", 32'(ram_if.trigger_en), 32'd0);
    check("midrst state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;

    // stop during POST with a simultaneous start
    div = '0; pre_num = '0; trig_mask = 8'h00; trig_edge = 8'h00; trig_val = 8'h00; din = 8'h11;
    pulse_start();
    repeat (50) @(posedge sys_clk);
    #1;
    check("stoppost in_post", 32'(state_dbg), 32'd3);
    stop = 1'b1; start = 1'b1;
    @(posedge sys_clk); #1 stop = 1'b0; start = 1'b0;
    check("stoppost wr_en", 32'(ram_if.wr_en), 32'd0);
    check("stoppost trigger_en", 32'(ram_if.trigger_en), 32'd0);
    check("stoppost done", 32'(done), 32'd0);
    act_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge sys_clk); #1;
      if (ram_if.wr_en || ram_if.trigger_en || done || state_dbg != 3'd0) act_cnt++;
    end
    check("stoppost stays_idle", act_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
